// File: rtl/test_if_core.sv
// Streaming moving average over the last 2^LOG2_DEPTH samples; one-cycle registered latency, valid-only (no backpressure).
// Define TEST_IF_CORE_ROUND_EN for round-half-up results; truncation otherwise.
module test_if_core #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in_vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_out_vld,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int N  = 1 << LOG2_DEPTH;
  localparam int SW = DATA_WIDTH + LOG2_DEPTH;

  typedef enum logic {FILL, RUN} state_t;

  state_t                  state, state_nxt;
  logic [LOG2_DEPTH-1:0]   count, count_nxt;
  logic [DATA_WIDTH-1:0]   dl [N];
  logic [SW-1:0]           sum, sum_nxt, rnd;
  logic                    fire;
  logic                    unused_bits;

  // Sum including the current sample; the oldest entry leaves the window.
  assign sum_nxt = sum + SW'(data_in) - SW'(dl[N-1]);

`ifdef TEST_IF_CORE_ROUND_EN
  assign rnd = sum_nxt + SW'(N / 2);
`else
  assign rnd = sum_nxt;
`endif

  assign unused_bits = ^rnd[LOG2_DEPTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    fire      = 1'b0;
    if (data_in_vld) begin
      case (state)
        FILL: begin
          if (count == LOG2_DEPTH'(N - 1)) begin
            fire      = 1'b1;
            state_nxt = RUN;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
        RUN: fire = 1'b1;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum          <= '0;
      data_out_vld <= 1'b0;
      data_out     <= '0;
      for (int i = 0; i < N; i++) dl[i] <= '0;
    end else begin
      data_out_vld <= fire;
      if (data_in_vld) begin
        sum   <= sum_nxt;
        dl[0] <= data_in;
        for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
      end
      if (fire) data_out <= rnd[SW-1:LOG2_DEPTH];
    end
  end

endmodule

// File: tb/tb_test_if_core.sv
// Directed bench for test_if_core (N=4): window model feeds a scoreboard of expected averages.
module tb_test_if_core;

  localparam int DW = 16;
  localparam int L2 = 2;
  localparam int N  = 4;
`ifdef TEST_IF_CORE_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_in_vld;
  logic [DW-1:0] data_in;
  logic          data_out_vld;
  logic [DW-1:0] data_out;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            win[$];
  int            acc_cnt;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_exp;
  logic          exp_vld;

  test_if_core #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_vld  (data_in_vld),
    .data_in      (data_in),
    .data_out_vld (data_out_vld),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    acc_cnt  = 0;
    last_exp = '0;
  endtask

  // Model: average recomputed from the whole window, independent of any running sum.
  task automatic model_accept(input logic [DW-1:0] d);
    longint s;
    win.push_front(int'(d));
    if (win.size() > N) void'(win.pop_back());
    acc_cnt++;
    exp_vld = (acc_cnt >= N);
    if (exp_vld) begin
      s = 0;
      foreach (win[i]) s += win[i];
      sb.push_back(DW'((s + RND) >> L2));
    end
  endtask

  // Called at a negedge; drives one cycle, checks after the edge, returns at the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    data_in_vld = v;
    data_in     = d;
    exp_vld     = 1'b0;
    if (v) model_accept(d);
    @(posedge clk); #1;
    chk("out_vld", data_out_vld, exp_vld);
    if (data_out_vld) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        chk("data_out", data_out, last_exp);
      end
    end else begin
      chk("data_hold", data_out, last_exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    data_in_vld = 1'b1;
    data_in     = '0;
    model_reset();

    // Samples under reset are discarded and outputs stay clear.
    for (int i = 0; i < 4; i++) begin
      data_in = DW'($urandom);
      @(posedge clk); #1;
      chk("rst_vld", data_out_vld, 0);
      chk("rst_data", data_out, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom));

    rst_n = 1'b0;
    #1;
    chk("rst2_vld", data_out_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Fill then sliding.
    step(1'b1, 16'd1);
    step(1'b1, 16'd2);
    step(1'b1, 16'd3);
    step(1'b1, 16'd4);
    step(1'b1, 16'd8);
    step(1'b1, 16'd0);
    step(1'b0, DW'($urandom));

    // Full scale up and back down.
    for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0000);

    // Fresh fill with idle gaps.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    begin
      logic [DW-1:0] gap_vals [5];
      gap_vals = '{16'd4, 16'd4, 16'd4, 16'd4, 16'd8};
      for (int i = 0; i < 5; i++) begin
        step(1'b1, gap_vals[i]);
        for (int g = 0, ng = $urandom_range(2, 5); g < ng; g++) step(1'b0, DW'($urandom));
      end
    end

    // Reset mid-stream in RUN: outputs clear before the next edge.
    step(1'b1, 16'd100);
    step(1'b1, 16'd200);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", data_out_vld, 0);
    chk("mid_rst_data", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 16'd10);
    step(1'b1, 16'd20);
    step(1'b1, 16'd30);
    step(1'b1, 16'd41);
    step(1'b1, 16'd7);
    step(1'b0, DW'($urandom));

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
